// File: rtl/pipeline_exe_muldiv.sv
// pipeline_exe_muldiv: iterative RV32M multiply/divide unit for the EXE stage
module pipeline_exe_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              md_start_e_i,
  input  logic [2:0]        md_op_e_i,
  input  logic [DATA_W-1:0] rs1_e_i,
  input  logic [DATA_W-1:0] rs2_e_i,
  input  logic              trap_flush_t_i,
  output logic              md_stall_o,
  output logic              md_valid_o,
  output logic [DATA_W-1:0] md_result_o
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op;
  logic neg_a, neg_b;
  logic [DATA_W-1:0] b;
  logic [2*DATA_W-1:0] acc, acc_nxt, prod;
  logic sa, sb, na, nb, div0, ovf;
  logic [DATA_W-1:0] abs_a, abs_b, spec_res, q, r, res;
  logic [DATA_W:0] sum, diff;
  always_comb begin
    sa = ~md_op_e_i[0] | (md_op_e_i == 3'b001);
    sb = sa & (md_op_e_i != 3'b010);
    na = sa & rs1_e_i[DATA_W-1];
    nb = sb & rs2_e_i[DATA_W-1];
    abs_a = na ? -rs1_e_i : rs1_e_i;
    abs_b = nb ? -rs2_e_i : rs2_e_i;
    div0 = md_op_e_i[2] & (rs2_e_i == '0);
    ovf = md_op_e_i[2] & ~md_op_e_i[0] & (rs1_e_i == {1'b1, {(DATA_W-1){1'b0}}}) & (rs2_e_i == '1);
    spec_res = div0 ? (md_op_e_i[1] ? rs1_e_i : '1) : (md_op_e_i[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}});
  end
  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b} : '0);
    diff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, b};
    acc_nxt = ~op[2] ? {sum, acc[DATA_W-1:1]}
            : diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
            : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    prod = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    q = acc_nxt[DATA_W-1:0];
    r = acc_nxt[2*DATA_W-1:DATA_W];
    res = op[2] ? (op[1] ? (neg_a ? -r : r) : ((neg_a ^ neg_b) ? -q : q))
        : (op == 3'b000 ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W]);
  end
  assign md_stall_o = resetn & ~trap_flush_t_i & (state == IDLE ? md_start_e_i : state == CALC);
  assign md_valid_o = state == DONE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      b <= '0;
      acc <= '0;
      md_result_o <= '0;
    end else if (trap_flush_t_i) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (md_start_e_i) begin
        op <= md_op_e_i;
        neg_a <= na;
        neg_b <= nb;
        b <= abs_b;
        acc <= {{DATA_W{1'b0}}, abs_a};
        cnt <= '0;
        state <= (div0 | ovf) ? DONE : CALC;
        if (div0 | ovf) md_result_o <= spec_res;
      end
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(DATA_W - 1)) begin
        state <= DONE;
        md_result_o <= res;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// tb_pipeline_exe_muldiv: randomized and directed checks against an arithmetic reference model
module tb_pipeline_exe_muldiv;
  logic clk = 0, resetn = 0, md_start_e_i = 0, trap_flush_t_i = 0;
  logic [2:0] md_op_e_i = 0;
  logic [31:0] rs1_e_i = 0, rs2_e_i = 0;
  logic md_stall_o, md_valid_o;
  logic [31:0] md_result_o;
  logic [31:0] last = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pipeline_exe_muldiv dut (
    .clk(clk), .resetn(resetn), .md_start_e_i(md_start_e_i), .md_op_e_i(md_op_e_i),
    .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i), .trap_flush_t_i(trap_flush_t_i),
    .md_stall_o(md_stall_o), .md_valid_o(md_valid_o), .md_result_o(md_result_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint xa, xb, sa, sb;
    logic [63:0] p;
    logic ov;
    xa = op == 3'b011 ? longint'({32'b0, a}) : longint'($signed(a));
    xb = op[1] ? longint'({32'b0, b}) : longint'($signed(b));
    p = 64'(xa * xb);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = a == 32'h80000000 && b == 32'hffffffff;
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hffffffff : ov ? 32'h80000000 : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hffffffff : a / b;
      3'd6: return b == 0 ? a : ov ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 6);
    return r == 0 ? 32'h0 : r == 1 ? 32'h1 : r == 2 ? 32'hffffffff : r == 3 ? 32'h80000000 : $urandom;
  endfunction
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    exp = model(op, a, b);
    lat = (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hffffffff))) ? 1 : 33;
    @(posedge clk); #1;
    md_start_e_i = 1; md_op_e_i = op; rs1_e_i = a; rs2_e_i = b;
    for (int k = 0; k < lat; k++) begin
      #1;
      chk("busy_stall", md_stall_o, 1);
      chk("busy_valid", md_valid_o, 0);
      @(posedge clk); #1;
      rs1_e_i = $urandom; rs2_e_i = $urandom;
    end
    chk("done_valid", md_valid_o, 1);
    chk("done_stall", md_stall_o, 0);
    chk($sformatf("result op%0d %h %h", op, a, b), md_result_o, exp);
    last = exp;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", md_stall_o, 0);
    chk("rst_valid", md_valid_o, 0);
    chk("rst_result", md_result_o, 0);
    @(negedge clk) resetn = 1;
    run(3'd0, 32'd7, 32'hfffffffd);
    run(3'd1, 32'h80000000, 32'h80000000);
    run(3'd3, 32'hffffffff, 32'hffffffff);
    run(3'd2, 32'hffffffff, 32'h2);
    run(3'd4, 32'hfffffff9, 32'h2);
    run(3'd6, 32'hfffffff9, 32'h2);
    run(3'd5, 32'd100, 32'd7);
    run(3'd7, 32'd100, 32'd7);
    run(3'd4, 32'd5, 32'd0);
    run(3'd7, 32'd5, 32'd0);
    run(3'd4, 32'h80000000, 32'hffffffff);
    run(3'd6, 32'h80000000, 32'hffffffff);
    for (int i = 0; i < 24; i++) run(3'($urandom_range(0, 7)), pick(), pick());
    @(posedge clk); #1;
    md_start_e_i = 0;
    @(posedge clk); #1;
    md_start_e_i = 1; md_op_e_i = 3'd0; rs1_e_i = 32'd123; rs2_e_i = 32'd456;
    repeat (10) @(posedge clk);
    #1 trap_flush_t_i = 1;
    #1 chk("flush_stall", md_stall_o, 0);
    @(posedge clk); #1;
    trap_flush_t_i = 0; md_start_e_i = 0;
    for (int k = 0; k < 34; k++) begin
      chk("flush_idle_stall", md_stall_o, 0);
      chk("flush_idle_valid", md_valid_o, 0);
      chk("flush_result", md_result_o, last);
      @(posedge clk); #1;
    end
    md_start_e_i = 1; trap_flush_t_i = 1;
    #1 chk("coinc_stall", md_stall_o, 0);
    @(posedge clk); #1;
    md_start_e_i = 0; trap_flush_t_i = 0;
    chk("coinc_not_taken", md_stall_o, 0);
    chk("coinc_valid", md_valid_o, 0);
    run(3'd0, 32'd6, 32'd7);
    @(posedge clk); #1;
    md_start_e_i = 1; md_op_e_i = 3'd0; rs1_e_i = 32'd11; rs2_e_i = 32'd13;
    repeat (20) @(posedge clk);
    #1 resetn = 0;
    #1;
    chk("arst_stall", md_stall_o, 0);
    chk("arst_valid", md_valid_o, 0);
    chk("arst_result", md_result_o, 0);
    md_start_e_i = 0;
    @(negedge clk) resetn = 1;
    run(3'd5, 32'd9, 32'd3);
    @(posedge clk); #1;
    md_start_e_i = 0;
    chk("post_valid", md_valid_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_exe_muldiv.md
Name: pipeline_exe_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EXE stage of the five-stage pipeline.
- Accepts M-extension operations decoded in ID and computes each one over multiple cycles, stalling IF/ID/EXE while it works.
- Presents a registered 32-bit result, which the EXE result mux selects onto alu_result_e_i / alu_calculation_e_i of the MEM stage.
- Honours trap flushes the same way the MEM stage does.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  pipeline clock.
- resetn  input  1  reset, asynchronous, active-low.
- md_start_e_i  input  1  level: the instruction in EXE is an M-op; held high until the stall releases.
- md_op_e_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_e_i  input  32  forwarded operand A.
- rs2_e_i  input  32  forwarded operand B.
- trap_flush_t_i  input  1  trap flush; aborts any operation in progress.
- md_stall_o  output  1  combinational; freezes PC, IF/ID and ID/EX while high.
- md_valid_o  output  1  one-cycle pulse: md_result_o is valid for the instruction in EXE.
- md_result_o  output  32  registered result; held until the next accepted start.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; counter=0; md_result_o=0; md_valid_o=0; internal product/remainder/quotient registers cleared.
  - md_stall_o=0 because state is IDLE and no start is accepted while resetn is low.
- States: IDLE, CALC, DONE.
- IDLE:
  - If md_start_e_i=1 and trap_flush_t_i=0, latch operands and op.
  - Set operand-sign flags: MUL/MULH/DIV/REM both signed; MULHSU rs1 signed only; unsigned ops neither.
  - Latch |rs1| and |rs2| for signed operands.
  - Go to CALC with counter=0, except for divide special cases, which go straight to DONE.
  - md_stall_o = md_start_e_i & ~trap_flush_t_i.
- Divide special cases, decided in IDLE and never entering CALC:
  - rs2=0: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU result rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, one iteration per cycle for exactly 32 cycles (counter 0..31), then DONE.
  - Multiply: radix-2 shift-add over the unsigned 64-bit product.
  - Divide: restoring shift-subtract producing 32-bit quotient and remainder.
  - md_stall_o=1 throughout.
- DONE:
  - md_valid_o=1 and md_stall_o=0; next state IDLE. md_start_e_i is ignored in DONE (it still belongs to the completing instruction).
  - Sign fix: negate the product if exactly one signed operand was negative.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
- md_result_o is written at the transition into DONE, so it is stable during the DONE cycle and afterwards.
- Latency:
  - Start accepted at cycle T: CALC runs T+1..T+32, DONE at T+33. Total EXE occupancy is 34 cycles.
  - Special-case divide: DONE at T+1 (2 cycles).
- Back-to-back M-ops: the next instruction enters EXE the cycle after DONE and is seen in IDLE. There is no idle bubble beyond the DONE cycle.
- trap_flush_t_i:
  - In any state, the next state is IDLE, md_valid_o is 0 on the next cycle, and md_result_o is unchanged.
  - A start coincident with a flush is not accepted. md_stall_o is forced low during the flush cycle so the flush can proceed.
- Reset mid-operation: immediate return to the reset values above; no md_valid_o pulse for the aborted op.
- md_valid_o is never asserted outside DONE. Operands change while stalled have no effect once latched.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, start held -> md_stall_o high for 33 cycles, md_valid_o at T+33, md_result_o=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each valid at T+33.
- Special cases, each with md_valid_o at T+1 and stall for exactly 1 cycle:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- MUL start, then trap_flush_t_i pulsed at T+10 -> state IDLE at T+11, md_stall_o low, no md_valid_o; md_result_o keeps its previous value.
- resetn dropped asynchronously mid-CALC at T+20 -> outputs zero immediately. After release, DIVU 9/3 runs cleanly -> 3 at T'+33.
